// File: rtl/rfid_token_bus_tx_if.sv
// Token-bus transmit interface: token handshake, 8-bit byte-strobe bus and checker verdict.
// master = the transmitter side, slave = the token source / bus receiver side.
interface rfid_token_bus_tx_if;
    logic [63:0] tok_data;
    logic        tok_valid;
    logic        tok_ready;
    logic [7:0]  bus_data;
    logic        bus_clk;
    logic        bus_latch;
    logic        valid_in;
    logic        replay_in;
    logic        result_valid;
    logic [1:0]  result_code;
    logic        busy;

    modport master (
        input  tok_data, tok_valid, valid_in, replay_in,
        output tok_ready, bus_data, bus_clk, bus_latch, result_valid, result_code, busy
    );

    modport slave (
        output tok_data, tok_valid, valid_in, replay_in,
        input  tok_ready, bus_data, bus_clk, bus_latch, result_valid, result_code, busy
    );
endinterface

// File: rtl/rfid_token_bus_tx.sv
// Sends one 64-bit token as 8 MSB-first byte strobes and reports a result code.
// Macro TX_RESP_CHECK_EN compiles in the checker verdict wait (synchronizers + timeout).
module rfid_token_bus_tx #(
    parameter int SETUP_CYC    = 4,
    parameter int HIGH_CYC     = 8,
    parameter int LOW_CYC      = 8,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    rfid_token_bus_tx_if.master    link
);

    localparam int MAX_SH  = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
    localparam int MAX_SHL = (MAX_SH > LOW_CYC) ? MAX_SH : LOW_CYC;
    localparam int MAX_ALL = (MAX_SHL > RESP_TIMEOUT) ? MAX_SHL : RESP_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_ALL) + 1;

`ifdef TX_RESP_CHECK_EN
    typedef enum logic [2:0] {IDLE, SETUP, STROBE_HI, STROBE_LO, RESP_WAIT, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, SETUP, STROBE_HI, STROBE_LO, DONE} state_t;
`endif

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [2:0]         idx_reg, idx_next;
    logic [63:0]        tok_sr_reg, tok_sr_next;
    logic [7:0]         bus_data_reg, bus_data_next;
    logic               bus_clk_reg, bus_clk_next;
    logic               bus_latch_reg, bus_latch_next;
    logic               tok_ready_reg, tok_ready_next;
    logic               busy_reg, busy_next;
    logic               result_valid_reg, result_valid_next;
    logic [1:0]         result_code_reg, result_code_next;

`ifdef TX_RESP_CHECK_EN
    // bit 0 = checker "valid", bit 1 = checker "replay"; both arrive asynchronously
    logic [1:0] flag_async;
    logic [1:0] flag_sync;

    assign flag_async = {link.replay_in, link.valid_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            always_ff @(posedge CLOCK_50 or posedge reset) begin
                if (reset) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= flag_async[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign flag_sync[gi] = s2_reg;
        end
    endgenerate
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            idx_reg          <= 3'd0;
            tok_sr_reg       <= 64'd0;
            bus_data_reg     <= 8'h00;
            bus_clk_reg      <= 1'b0;
            bus_latch_reg    <= 1'b0;
            tok_ready_reg    <= 1'b1;
            busy_reg         <= 1'b0;
            result_valid_reg <= 1'b0;
            result_code_reg  <= 2'b00;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            idx_reg          <= idx_next;
            tok_sr_reg       <= tok_sr_next;
            bus_data_reg     <= bus_data_next;
            bus_clk_reg      <= bus_clk_next;
            bus_latch_reg    <= bus_latch_next;
            tok_ready_reg    <= tok_ready_next;
            busy_reg         <= busy_next;
            result_valid_reg <= result_valid_next;
            result_code_reg  <= result_code_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg + CNT_W'(1);
        idx_next          = idx_reg;
        tok_sr_next       = tok_sr_reg;
        bus_data_next     = bus_data_reg;
        bus_clk_next      = bus_clk_reg;
        bus_latch_next    = bus_latch_reg;
        result_valid_next = 1'b0;
        result_code_next  = result_code_reg;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (link.tok_valid && tok_ready_reg) begin
                    tok_sr_next    = link.tok_data;
                    idx_next       = 3'd0;
                    bus_data_next  = link.tok_data[63:56];
                    bus_latch_next = 1'b1;
                    bus_clk_next   = 1'b0;
                    state_next     = SETUP;
                end
            end
            SETUP: begin
                if (cnt_reg == CNT_W'(SETUP_CYC - 1)) begin
                    cnt_next     = '0;
                    bus_clk_next = 1'b1;
                    state_next   = STROBE_HI;
                end
            end
            STROBE_HI: begin
                if (cnt_reg == CNT_W'(HIGH_CYC - 1)) begin
                    cnt_next     = '0;
                    bus_clk_next = 1'b0;
                    state_next   = STROBE_LO;
                end
            end
            STROBE_LO: begin
                if (cnt_reg == CNT_W'(LOW_CYC - 1)) begin
                    cnt_next = '0;
                    if (idx_reg != 3'd7) begin
                        // next byte goes out only here, keeping bus_data stable over a full byte period
                        idx_next      = idx_reg + 3'd1;
                        tok_sr_next   = tok_sr_reg << 8;
                        bus_data_next = tok_sr_reg[55:48];
                        state_next    = SETUP;
                    end else begin
                        bus_latch_next = 1'b0;
                        bus_data_next  = 8'h00;
`ifdef TX_RESP_CHECK_EN
                        state_next     = RESP_WAIT;
`else
                        state_next        = DONE;
                        result_valid_next = 1'b1;
                        result_code_next  = 2'b00;
`endif
                    end
                end
            end
`ifdef TX_RESP_CHECK_EN
            RESP_WAIT: begin
                if (flag_sync == 2'b11) begin
                    state_next        = DONE;
                    result_valid_next = 1'b1;
                    result_code_next  = 2'b11;
                end else if (flag_sync[0]) begin
                    state_next        = DONE;
                    result_valid_next = 1'b1;
                    result_code_next  = 2'b01;
                end else if (flag_sync[1]) begin
                    state_next        = DONE;
                    result_valid_next = 1'b1;
                    result_code_next  = 2'b10;
                end else if (cnt_reg == CNT_W'(RESP_TIMEOUT - 1)) begin
                    state_next        = DONE;
                    result_valid_next = 1'b1;
                    result_code_next  = 2'b11;
                end
            end
`endif
            DONE: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase

        // handshake flags follow the state being entered so they are registered with it
        tok_ready_next = (state_next == IDLE);
        busy_next      = (state_next != IDLE);
    end

    assign link.tok_ready    = tok_ready_reg;
    assign link.bus_data     = bus_data_reg;
    assign link.bus_clk      = bus_clk_reg;
    assign link.bus_latch    = bus_latch_reg;
    assign link.result_valid = result_valid_reg;
    assign link.result_code  = result_code_reg;
    assign link.busy         = busy_reg;

endmodule

// File: tb/tb_rfid_token_bus_tx.sv
// Randomized self-checking bench for rfid_token_bus_tx; the reference model derives byte order,
// strobe timing and verdicts from the frame rules and a set of previously accepted tokens.
module tb_rfid_token_bus_tx;

    localparam int S     = 4;
    localparam int H     = 8;
    localparam int L     = 8;
    localparam int RT    = 64;
    localparam int P     = S + H + L;
    localparam int FRAME = 8 * P;

    localparam int MODE_CHECKER = 0;
    localparam int MODE_SILENT  = 1;
    localparam int MODE_BOTH    = 2;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;

    rfid_token_bus_tx_if link();

    rfid_token_bus_tx #(
        .SETUP_CYC    (S),
        .HIGH_CYC     (H),
        .LOW_CYC      (L),
        .RESP_TIMEOUT (RT)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .link     (link)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_errors = 0;
    bit seen [logic [63:0]];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Verdict the checker would give; only the "real checker" mode remembers tokens.
    function automatic logic [1:0] model_code(input logic [63:0] tok, input int mode);
`ifdef TX_RESP_CHECK_EN
        if (mode == MODE_CHECKER) begin
            if (seen.exists(tok)) return 2'b10;
            seen[tok] = 1'b1;
            return 2'b01;
        end
        return 2'b11;
`else
        return 2'b00;
`endif
    endfunction

    // Cycles from the token-accept edge to the result_valid cycle.
    function automatic int model_done(input int mode, input int d);
`ifdef TX_RESP_CHECK_EN
        if (mode == MODE_SILENT) return FRAME + RT;
        return FRAME + 3 + d;
`else
        return FRAME + 0 * (mode + d);
`endif
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (link.tok_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLOCK_50);
        end
        if (!ok) check_eq("ready_wait", 64'd0, 64'd1);
    endtask

    task automatic run_frame(input logic [63:0] tok, input int mode, input int d);
        bit         ok;
        int         rises;
        int         rv_cnt;
        int         rv_t;
        int         exp_done;
        logic [1:0] code;
        logic [1:0] exp_code;
        logic [7:0] eb;
        logic       prev_clk;
        wait_ready(ok);
        if (!ok) return;
        exp_code = model_code(tok, mode);
        exp_done = model_done(mode, d);
        link.tok_data  = tok;
        link.tok_valid = 1'b1;
        @(negedge CLOCK_50);
        link.tok_valid = 1'b0;
        check_eq("start_ready", link.tok_ready, 0);
        check_eq("start_busy",  link.busy, 1);
        check_eq("start_latch", link.bus_latch, 1);
        rises = 0; rv_cnt = 0; rv_t = -1; code = 2'b00; prev_clk = 1'b0;
        for (int t = 0; t <= exp_done + 1; t++) begin
            if (link.bus_clk && !prev_clk) begin
                check_eq("rise_time", t, S + rises * P);
                eb = (rises < 8) ? tok[63 - 8 * rises -: 8] : 8'h00;
                check_eq("rise_byte", link.bus_data, eb);
                check_eq("rise_latch", link.bus_latch, 1);
                rises++;
            end
            if (!link.bus_clk && prev_clk) begin
                eb = (rises >= 1 && rises <= 8) ? tok[63 - 8 * (rises - 1) -: 8] : 8'h00;
                check_eq("fall_byte", link.bus_data, eb);
            end
            if (t == FRAME) begin
                check_eq("end_latch", link.bus_latch, 0);
                check_eq("end_data",  link.bus_data, 0);
            end
            if (link.result_valid) begin
                rv_cnt++;
                rv_t = t;
                code = link.result_code;
            end
            if (t == exp_done + 1) begin
                check_eq("after_ready", link.tok_ready, 1);
                check_eq("after_busy",  link.busy, 0);
            end
            prev_clk = link.bus_clk;
            // checker side: flags cleared by the first strobe, raised after the frame
            if (t == S) begin
                link.valid_in  = 1'b0;
                link.replay_in = 1'b0;
            end
`ifdef TX_RESP_CHECK_EN
            if (t == FRAME + d && mode != MODE_SILENT) begin
                link.valid_in  = (mode == MODE_BOTH) || (exp_code == 2'b01);
                link.replay_in = (mode == MODE_BOTH) || (exp_code == 2'b10);
            end
`else
            if (t > S) begin
                link.valid_in  = 1'($urandom_range(0, 1));
                link.replay_in = 1'($urandom_range(0, 1));
            end
`endif
            @(negedge CLOCK_50);
        end
        check_eq("rise_count", rises, 8);
        check_eq("result_pulses", rv_cnt, 1);
        check_eq("result_time", rv_t, exp_done);
        check_eq("result_code", code, exp_code);
        $display("frame tok=%016h mode=%0d d=%0d code=%0d at=%0d", tok, mode, d, code, rv_t);
    endtask

    task automatic reset_mid_frame(input logic [63:0] tok);
        bit   ok;
        int   rises;
        int   rv;
        logic prev_clk;
        wait_ready(ok);
        if (!ok) return;
        link.tok_data  = tok;
        link.tok_valid = 1'b1;
        @(negedge CLOCK_50);
        link.tok_valid = 1'b0;
        rises = 0; rv = 0; prev_clk = 1'b0;
        for (int t = 0; t < 200 && rises < 3; t++) begin
            if (link.bus_clk && !prev_clk) rises++;
            if (link.result_valid) rv++;
            prev_clk = link.bus_clk;
            if (rises < 3) @(negedge CLOCK_50);
        end
        check_eq("rst_rises", rises, 3);
        repeat (2) @(negedge CLOCK_50);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_clk",   link.bus_clk, 0);
        check_eq("rst_latch", link.bus_latch, 0);
        check_eq("rst_data",  link.bus_data, 0);
        check_eq("rst_ready", link.tok_ready, 1);
        check_eq("rst_busy",  link.busy, 0);
        repeat (3) begin
            @(negedge CLOCK_50);
            if (link.result_valid) rv++;
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge CLOCK_50);
            if (link.result_valid) rv++;
        end
        check_eq("rst_no_result", rv, 0);
        $display("frame tok=%016h aborted by reset after %0d strobes", tok, rises);
    endtask

    task automatic back_to_back();
        bit         ok;
        int         period;
        int         window;
        int         n;
        int         times [4];
        logic [1:0] exp_code;
`ifdef TX_RESP_CHECK_EN
        period   = FRAME + RT + 2;
        exp_code = 2'b11;
`else
        period   = FRAME + 2;
        exp_code = 2'b00;
`endif
        window = 3 * period + 10;
        link.valid_in  = 1'b0;
        link.replay_in = 1'b0;
        wait_ready(ok);
        if (!ok) return;
        link.tok_data  = {$urandom, $urandom};
        link.tok_valid = 1'b1;
        n = 0;
        for (int u = 1; u <= window; u++) begin
            @(negedge CLOCK_50);
            if (link.result_valid) begin
                if (n < 4) times[n] = u;
                n++;
                check_eq("b2b_code", link.result_code, exp_code);
            end
        end
        link.tok_valid = 1'b0;
        check_eq("b2b_count", n, 3);
        if (n >= 3) begin
            check_eq("b2b_first", times[0], period - 1);
            check_eq("b2b_gap1", times[1] - times[0], period);
            check_eq("b2b_gap2", times[2] - times[1], period);
            $display("back-to-back frames done at %0d %0d %0d", times[0], times[1], times[2]);
        end
    endtask

    initial begin
        logic [63:0] tok;
        logic [63:0] prev_tok;
        link.tok_data  = 64'd0;
        link.tok_valid = 1'b0;
        link.valid_in  = 1'b0;
        link.replay_in = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check_eq("reset_ready", link.tok_ready, 1);
        check_eq("reset_data",  link.bus_data, 0);
        check_eq("reset_clk",   link.bus_clk, 0);
        check_eq("reset_latch", link.bus_latch, 0);
        check_eq("reset_rv",    link.result_valid, 0);
        check_eq("reset_code",  link.result_code, 0);
        check_eq("reset_busy",  link.busy, 0);
        reset = 1'b0;
        @(negedge CLOCK_50);

        run_frame(64'h0123_4567_89AB_CDEF, MODE_CHECKER, 5);
        run_frame(64'h0123_4567_89AB_CDEF, MODE_CHECKER, 12);
        run_frame({$urandom, $urandom}, MODE_SILENT, 0);
        run_frame({$urandom, $urandom}, MODE_BOTH, 7);
        reset_mid_frame({$urandom, $urandom});
        back_to_back();

        prev_tok = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 6; i++) begin
            tok = (i % 3 == 2) ? prev_tok : {$urandom, $urandom};
            run_frame(tok, int'($urandom_range(0, 2)), int'($urandom_range(0, 40)));
            prev_tok = tok;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
